// File: rtl/spi_slave_fifos.sv
// SPI slave (modes 0-3, selectable bit order) with first-word-fall-through TX/RX byte FIFOs.
// Define SPI_SLAVE_ERR_FLAGS_EN to enable the sticky rx_overflow/tx_underrun flags and err_clr.
module spi_slave_fifos #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       msb_first,
    input  logic [7:0] tx_wdata,
    input  logic       tx_wvalid,
    output logic       tx_wready,
    output logic [7:0] rx_rdata,
    output logic       rx_rvalid,
    input  logic       rx_rready,
    output logic       busy,
    output logic       byte_done,
    output logic       rx_overflow,
    output logic       tx_underrun,
    input  logic       err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = (AW)'(1);
    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   armed_q, armed_d;
    logic [0:0]             state_q, state_d;
    logic                   mode_cpol_q, mode_cpol_d;
    logic                   mode_cpha_q, mode_cpha_d;
    logic                   mode_msb_q, mode_msb_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [7:0]             rx_shift_q, rx_shift_d;
    logic                   byte_done_q, byte_done_d;
    logic [7:0]             tx_mem_q [FIFO_DEPTH];
    logic [7:0]             tx_mem_d [FIFO_DEPTH];
    logic [7:0]             rx_mem_q [FIFO_DEPTH];
    logic [7:0]             rx_mem_d [FIFO_DEPTH];
    logic [AW-1:0]          tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW-1:0]          rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [AW:0]            tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic active;
    logic tx_load, tx_push, tx_pop, rx_push, rx_pop;
    logic underrun_set, overflow_set;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    // armed_q blocks a false frame start when cs_n is still low as the preset synchronizer drains after reset
    assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign active    = (state_q == ST_ACTIVE);

    assign lead_edge   = mode_cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = mode_cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = active & ~cs_rise & (mode_cpha_q ? trail_edge : lead_edge);
    assign shift_edge  = active & ~cs_rise & (mode_cpha_q ? lead_edge : trail_edge);

    assign tx_load      = ((state_q == ST_IDLE) & cs_fall & ~cpha) | (shift_edge & (bit_cnt_q == 3'd0));
    assign tx_pop       = tx_load & (tx_cnt_q != '0);
    assign underrun_set = tx_load & (tx_cnt_q == '0);
    assign tx_push      = tx_wvalid & tx_wready;
    assign rx_pop       = rx_rready & rx_rvalid;
    assign rx_push      = byte_done_q & ((rx_cnt_q != DEPTH_C) | rx_pop);
    assign overflow_set = byte_done_q & ~rx_push;

    assign tx_wready = (tx_cnt_q < DEPTH_C);
    assign rx_rvalid = (rx_cnt_q != '0);
    assign rx_rdata  = rx_rvalid ? rx_mem_q[rx_rd_q] : 8'h00;
    assign miso      = active & (mode_msb_q ? tx_shift_q[7] : tx_shift_q[0]);
    assign miso_oe   = active;
    assign busy      = active;
    assign byte_done = byte_done_q;

    always_comb begin
        sclk_sync_d[0] = sclk;
        cs_sync_d[0]   = cs_n;
        mosi_sync_d[0] = mosi;
        fill_d[0]      = 1'b1;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sclk_sync_d[i] = sclk_sync_q[i-1];
            cs_sync_d[i]   = cs_sync_q[i-1];
            mosi_sync_d[i] = mosi_sync_q[i-1];
            fill_d[i]      = fill_q[i-1];
        end
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
        state_d     = state_q;
        mode_cpol_d = mode_cpol_q;
        mode_cpha_d = mode_cpha_q;
        mode_msb_d  = mode_msb_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        byte_done_d = sample_edge & (bit_cnt_q == 3'd7);

        if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                state_d     = ST_ACTIVE;
                mode_cpol_d = cpol;
                mode_cpha_d = cpha;
                mode_msb_d  = msb_first;
                bit_cnt_d   = 3'd0;
            end
        end else if (cs_rise) begin
            state_d = ST_IDLE;
        end

        if (sample_edge) begin
            rx_shift_d = mode_msb_q ? {rx_shift_q[6:0], mosi_s} : {mosi_s, rx_shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
        end

        if (tx_load) begin
            tx_shift_d = tx_pop ? tx_mem_q[tx_rd_q] : 8'h00;
        end else if (shift_edge) begin
            tx_shift_d = mode_msb_q ? {tx_shift_q[6:0], 1'b0} : {1'b0, tx_shift_q[7:1]};
        end
    end

    always_comb begin
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        if (tx_push) tx_mem_d[tx_wr_q] = tx_wdata;
        if (rx_push) rx_mem_d[rx_wr_q] = rx_shift_q;
        tx_wr_d = tx_push ? tx_wr_q + PTR_ONE : tx_wr_q;
        tx_rd_d = tx_pop  ? tx_rd_q + PTR_ONE : tx_rd_q;
        rx_wr_d = rx_push ? rx_wr_q + PTR_ONE : rx_wr_q;
        rx_rd_d = rx_pop  ? rx_rd_q + PTR_ONE : rx_rd_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            mode_cpol_q <= 1'b0;
            mode_cpha_q <= 1'b0;
            mode_msb_q  <= 1'b1;
            bit_cnt_q   <= 3'd0;
            tx_shift_q  <= 8'h00;
            rx_shift_q  <= 8'h00;
            byte_done_q <= 1'b0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            fill_q      <= fill_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            mode_cpol_q <= mode_cpol_d;
            mode_cpha_q <= mode_cpha_d;
            mode_msb_q  <= mode_msb_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            byte_done_q <= byte_done_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counts alone.
    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

`ifdef SPI_SLAVE_ERR_FLAGS_EN
    logic rx_overflow_q, rx_overflow_d;
    logic tx_underrun_q, tx_underrun_d;

    always_comb begin
        rx_overflow_d = (rx_overflow_q & ~err_clr) | overflow_set;
        tx_underrun_d = (tx_underrun_q & ~err_clr) | underrun_set;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_overflow_q <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            rx_overflow_q <= rx_overflow_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign rx_overflow = rx_overflow_q;
    assign tx_underrun = tx_underrun_q;
`else
    logic unused_err;
    assign unused_err  = err_clr ^ overflow_set ^ underrun_set;
    assign rx_overflow = 1'b0;
    assign tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_fifos.sv
// Directed bench for spi_slave_fifos: behavioural SPI master drives frames in all modes and
// checks returned bytes, FIFO ordering, overflow/underrun and partial-byte handling.
`timescale 1ns/1ps
module tb_spi_slave_fifos;
    localparam int HALF = 8;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    localparam logic EXP_FLAG = 1'b1;
`else
    localparam logic EXP_FLAG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       msb_first = 1'b1;
    logic [7:0] tx_wdata = 8'h00;
    logic       tx_wvalid = 1'b0;
    logic       rx_rready = 1'b0;
    logic       err_clr = 1'b0;
    logic       miso, miso_oe, tx_wready, rx_rvalid, busy, byte_done, rx_overflow, tx_underrun;
    logic [7:0] rx_rdata;

    int         n_checks = 0;
    int         n_pass = 0;
    int         bd_cnt = 0;
    logic [7:0] m_tx [32];
    logic [7:0] m_rx [32];

    spi_slave_fifos #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .nrst(nrst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
        .tx_wdata(tx_wdata), .tx_wvalid(tx_wvalid), .tx_wready(tx_wready),
        .rx_rdata(rx_rdata), .rx_rvalid(rx_rvalid), .rx_rready(rx_rready),
        .busy(busy), .byte_done(byte_done), .rx_overflow(rx_overflow),
        .tx_underrun(tx_underrun), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (byte_done) bd_cnt <= bd_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        int g = 0;
        tx_wdata  = d;
        tx_wvalid = 1'b1;
        while (!tx_wready && g < 200) begin
            wait_clk(1);
            g++;
        end
        if (!tx_wready) checkOutput("push_timeout", 32'd0, 32'd1);
        wait_clk(1);
        tx_wvalid = 1'b0;
    endtask

    task automatic pop_rx(output logic [7:0] d);
        int g = 0;
        while (!rx_rvalid && g < 200) begin
            wait_clk(1);
            g++;
        end
        if (!rx_rvalid) checkOutput("pop_timeout", 32'd0, 32'd1);
        d = rx_rdata;
        rx_rready = 1'b1;
        wait_clk(1);
        rx_rready = 1'b0;
    endtask

    task automatic drain_rx();
        logic [7:0] d;
        for (int i = 0; i < 64 && rx_rvalid; i++) pop_rx(d);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(1);
    endtask

    // One SPI frame of nbits bits; master sends m_tx[] and collects miso into m_rx[].
    task automatic applyStimulus(input logic pol, input logic pha, input logic msbf, input int nbits);
        logic [7:0] rxb;
        int bi, bt, idx;
        cpol = pol; cpha = pha; msb_first = msbf;
        sclk = pol; mosi = 1'b0; rxb = 8'h00;
        wait_clk(8);
        cs_n = 1'b0;
        wait_clk(HALF + 4);
        checkOutput("busy_in_frame", busy, 1);
        checkOutput("oe_in_frame", miso_oe, 1);
        for (int k = 0; k < nbits; k++) begin
            bi = k / 8;
            bt = k % 8;
            idx = msbf ? 7 - bt : bt;
            if (!pha) begin
                mosi = m_tx[bi][idx];
                wait_clk(HALF);
                rxb = msbf ? {rxb[6:0], miso} : {miso, rxb[7:1]};
                sclk = ~sclk;
                wait_clk(HALF);
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                mosi = m_tx[bi][idx];
                wait_clk(HALF);
                rxb = msbf ? {rxb[6:0], miso} : {miso, rxb[7:1]};
                sclk = ~sclk;
                wait_clk(HALF);
            end
            if (bt == 7) m_rx[bi] = rxb;
        end
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(10);
        checkOutput("busy_after_frame", busy, 0);
        checkOutput("oe_after_frame", miso_oe, 0);
    endtask

    initial begin
        logic [7:0] d;
        int start;
        wait_clk(5);
        checkOutput("rst_miso", miso, 0);
        checkOutput("rst_miso_oe", miso_oe, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_byte_done", byte_done, 0);
        checkOutput("rst_rx_rvalid", rx_rvalid, 0);
        checkOutput("rst_tx_wready", tx_wready, 1);
        checkOutput("rst_rx_rdata", rx_rdata, 0);
        checkOutput("rst_rx_overflow", rx_overflow, 0);
        checkOutput("rst_tx_underrun", tx_underrun, 0);
        nrst = 1'b1;
        wait_clk(10);

        push_tx(8'hA5);
        m_tx[0] = 8'h3C;
        start = bd_cnt;
        applyStimulus(1'b0, 1'b0, 1'b1, 8);
        checkOutput("m0_miso_byte", m_rx[0], 8'hA5);
        checkOutput("m0_byte_done_cnt", bd_cnt - start, 1);
        checkOutput("m0_rx_rvalid", rx_rvalid, 1);
        pop_rx(d);
        checkOutput("m0_rx_rdata", d, 8'h3C);
        checkOutput("m0_rx_empty", rx_rvalid, 0);
        pulse_clr();

        for (int m = 1; m < 4; m++) begin
            push_tx(8'h01);
            m_tx[0] = 8'h80;
            applyStimulus(m[1], m[0], 1'b0, 8);
            checkOutput($sformatf("mode%0d_miso_byte", m), m_rx[0], 8'h01);
            pop_rx(d);
            checkOutput($sformatf("mode%0d_rx_rdata", m), d, 8'h80);
            pulse_clr();
        end

        checkOutput("underrun_pre", tx_underrun, 0);
        m_tx[0] = 8'h11;
        m_tx[1] = 8'h22;
        start = bd_cnt;
        applyStimulus(1'b0, 1'b0, 1'b1, 16);
        checkOutput("ur_miso_byte0", m_rx[0], 8'h00);
        checkOutput("ur_miso_byte1", m_rx[1], 8'h00);
        checkOutput("ur_flag_set", tx_underrun, EXP_FLAG);
        checkOutput("ur_byte_done_cnt", bd_cnt - start, 2);
        pop_rx(d);
        checkOutput("ur_rx_byte0", d, 8'h11);
        pop_rx(d);
        checkOutput("ur_rx_byte1", d, 8'h22);
        pulse_clr();
        checkOutput("ur_flag_cleared", tx_underrun, 0);

        for (int i = 0; i < 17; i++) m_tx[i] = 8'(8'h40 + i);
        start = bd_cnt;
        applyStimulus(1'b0, 1'b1, 1'b1, 17 * 8);
        checkOutput("ovf_flag_set", rx_overflow, EXP_FLAG);
        checkOutput("ovf_byte_done_cnt", bd_cnt - start, 17);
        for (int i = 0; i < 16; i++) begin
            pop_rx(d);
            checkOutput($sformatf("ovf_rx_byte%0d", i), d, 8'(8'h40 + i));
        end
        checkOutput("ovf_rx_empty", rx_rvalid, 0);
        pulse_clr();
        checkOutput("ovf_flag_cleared", rx_overflow, 0);

        m_tx[0] = 8'hFF;
        start = bd_cnt;
        applyStimulus(1'b0, 1'b0, 1'b1, 5);
        checkOutput("part_no_push", rx_rvalid, 0);
        checkOutput("part_no_byte_done", bd_cnt - start, 0);
        m_tx[0] = 8'h5A;
        applyStimulus(1'b0, 1'b0, 1'b1, 8);
        pop_rx(d);
        checkOutput("part_next_byte", d, 8'h5A);
        pulse_clr();

        for (int i = 0; i < 10; i++) push_tx(8'(8'hC0 + i));
        applyStimulus(1'b0, 1'b1, 1'b1, 32);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("wrap_a_byte%0d", i), m_rx[i], 8'(8'hC0 + i));
        drain_rx();
        for (int i = 0; i < 10; i++) begin
            push_tx(8'(8'hCA + i));
            checkOutput($sformatf("wrap_wready%0d", i), tx_wready, (i == 9) ? 1'b0 : 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 128);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("wrap_b_byte%0d", i), m_rx[i], 8'(8'hC4 + i));
        drain_rx();
        checkOutput("wrap_wready_end", tx_wready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
